// File: rtl/load_store_unit.sv
// RV32I load/store sequencer sitting in front of a memory that only reads and writes whole words.
// Sub-word stores read the containing word first, merge the new lane, then write it back.
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iStart,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oMisaligned,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWData,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemRData
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    RMW_READ  = 3'd3,
    RMW_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        misaligned_q, misaligned_d;

  logic        req_invalid;
  logic        req_misaligned;
  logic        req_fault;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] merge_word;

  // bu/hu only exist as loads, so a store carrying funct3[2] is rejected too
  always_comb begin
    req_invalid    = (iFunct3 == 3'b011) || (iFunct3[2:1] == 2'b11) || (iWrite && iFunct3[2]);
    req_misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      req_misaligned = ((iFunct3[1:0] == 2'b01) && iAddress[0]) ||
                       ((iFunct3[1:0] == 2'b10) && (iAddress[1:0] != 2'b00));
    end
    req_fault = req_invalid || req_misaligned;
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   load_byte = iMemRData[7:0];
      2'b01:   load_byte = iMemRData[15:8];
      2'b10:   load_byte = iMemRData[23:16];
      default: load_byte = iMemRData[31:24];
    endcase
    load_half = addr_q[1] ? iMemRData[31:16] : iMemRData[15:0];
    case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'h000000, load_byte};
      3'b101:  load_value = {16'h0000, load_half};
      default: load_value = iMemRData;
    endcase
  end

  // Replace only the addressed lane of the word captured during RMW_READ
  always_comb begin
    merge_word = merge_q;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merge_word[7:0]   = wdata_q[7:0];
        2'b01:   merge_word[15:8]  = wdata_q[7:0];
        2'b10:   merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    merge_d      = merge_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          addr_d   = iAddress;
          funct3_d = iFunct3;
          wdata_d  = iWData;
          write_d  = iWrite;
          if (req_fault) begin
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else if (!iWrite) begin
            state_d = LOAD;
          end else if (iFunct3[1:0] == 2'b10) begin
            state_d = STORE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      LOAD: begin
        rdata_d = load_value;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      STORE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RMW_READ: begin
        merge_d = iMemRData;
        state_d = RMW_WRITE;
      end
      RMW_WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      merge_q      <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      merge_q      <= merge_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Memory side is driven straight from the state so strobes line up with the access cycle
  always_comb begin
    oMemAddress = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    oMemRead    = (state_q == LOAD) || (state_q == RMW_READ);
    oMemWrite   = (state_q == STORE) || (state_q == RMW_WRITE);
    case (state_q)
      STORE:     oMemWData = wdata_q;
      RMW_WRITE: oMemWData = merge_word;
      default:   oMemWData = 32'h0;
    endcase
  end

  assign oRData      = rdata_q;
  assign oBusy       = (state_q != IDLE);
  assign oDone       = done_q;
  assign oMisaligned = misaligned_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the multicycle datapath and the unified data/instruction memory.
- Turns one load/store request per transaction into word-aligned memory accesses.
- Handles RV32I widths: lb, lh, lw, lbu, lhu, sb, sh, sw.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- Loads are extracted and extended from the word the memory returns. It latches at negedge while read is high, so the word is valid at the next posedge.

Parameters:
CHECK_ALIGN, 1, 1 = misaligned requests fault with no memory access; 0 = low address bits are ignored (lw/sw use addr[31:2], lh/sh use addr[1]).

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high
iStart  input  1  request strobe; sampled only in IDLE
iWrite  input  1  1 = store, 0 = load
iFunct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are valid for loads only)
iAddress  input  32  byte address
iWData  input  32  store data (low byte/half used for sb/sh)
oRData  output  32  extended load result
oBusy  output  1  high whenever state != IDLE
oDone  output  1  one-cycle completion pulse
oMisaligned  output  1  fault flag; valid only while oDone = 1
oMemAddress  output  32  {addr_q[31:2], 2'b00}
oMemWData  output  32  word to write
oMemWrite  output  1  memory write strobe
oMemRead  output  1  memory read strobe
iMemRData  input  32  memory read word

Behaviour:
- States: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE.
- Memory-side outputs are combinational from state and the latched request.
- oMemWrite/oMemRead are 0 in IDLE. oMemAddress = 0 in IDLE.
- Reset values: state = IDLE, oRData = 0, oDone = 0, oMisaligned = 0, all latches 0.
- IDLE, iStart = 1 at edge E0:
  - Latch address, funct3, wdata and write.
  - Fault check: the request faults if funct3 is invalid (011, 110, 111; or 100/101 with iWrite = 1).
  - With CHECK_ALIGN = 1, it also faults on halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Fault: stay IDLE. oDone = 1 and oMisaligned = 1 during E0→E1. No memory strobe at any point.
  - Otherwise go to LOAD (load), STORE (sw) or RMW_READ (sb/sh).
- LOAD (E0→E1): oMemRead = 1. At E1 capture iMemRData, extract and extend, update oRData, go IDLE, oDone = 1 during E1→E2.
- STORE (E0→E1): oMemWrite = 1, oMemWData = wdata. The memory writes at E1. Go IDLE, oDone = 1 during E1→E2.
- RMW_READ (E0→E1): oMemRead = 1. At E1 latch the word into merge_q and go to RMW_WRITE.
- RMW_WRITE (E1→E2): oMemWrite = 1, oMemWData = merge_q with the target lane replaced. At E2 go IDLE, oDone = 1 during E2→E3.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half at addr[1] occupies [15:0] or [31:16].
- Extension: b/h sign-extend; bu/hu zero-extend; w passes through.
- oRData holds its value except on LOAD completion; stores and faults leave it unchanged.
- Latencies, from the start edge to the end of the oDone pulse: load 2 cycles, sw 2, sb/sh 3, fault 1.
- Back-to-back: a new iStart is accepted in the same cycle oDone is high (state is IDLE).
- iStart while oBusy = 1 is ignored: no queueing and no effect on the latched request.
- Input changes after the start edge have no effect.
- oDone is never high for two consecutive cycles for the same request.
- Reset mid-operation:
  - Returns to IDLE at that edge and clears oDone/oMisaligned.
  - A write strobe already presented in that cycle still lands, since the memory has no reset.
  - No strobe is asserted after the reset edge.

Test Plan:
1. sw at 0x10010008 with wdata 0x80FF7F01, then lw from the same address → oMemWrite high for exactly 1 cycle; oRData = 0x80FF7F01; oDone one cycle after each access.
2. With word 0x80FF7F01 in memory: lb at +0 → 0x00000001; lb +1 → 0x0000007F; lb +2 → 0xFFFFFFFF; lbu +3 → 0x00000080; lh +2 → 0xFFFF80FF; lhu +2 → 0x000080FF.
3. sb 0xAA at 0x10010009, then sh 0x1234 at 0x1001000A, then lw → 0x1234AA01. Each store shows read then write and oBusy for exactly 2 cycles.
4. CHECK_ALIGN = 1: lw at 0x10010006, sh at 0x10010005, and a load with funct3 = 011 → oDone = oMisaligned = 1 in the cycle after start, no memory strobes, oRData unchanged.
5. iStart held high continuously with alternating lw/sw requests → each request is accepted in its oDone cycle; iStart during the busy cycles is ignored and the request count matches the oDone count.
6. reset asserted during RMW_READ of an sb → next cycle IDLE, oBusy = 0, no oMemWrite ever asserted, memory word unchanged.
